// File: rtl/lumatint_pkg.sv
// rtl/lumatint_pkg.sv - shared constants and tint set type for the luma colouriser
package lumatint_pkg;

    localparam int TINT_W   = 8;
    localparam int PIPE_LAT = 2;

    localparam logic [TINT_W-1:0] TINT_UNITY = 8'd255;

    typedef struct packed {
        logic [TINT_W-1:0] r;
        logic [TINT_W-1:0] g;
        logic [TINT_W-1:0] b;
    } tint_t;

endpackage

// File: rtl/lumatint_channel.sv
// rtl/lumatint_channel.sv - one colour channel: gain multiply, shift, lift and saturate
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   y_in         luma sample entering stage 1
//   gain         tint gain for this sample (255 = unity)
//   lift         black-level offset for this sample
//   en_s1        enable carried alongside the stage-1 sample
//   c_out        channel output, two cycles after y_in
module lumatint_channel
    import lumatint_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     y_in,
    input  logic [TINT_W-1:0] gain,
    input  logic [DW-1:0]     lift,
    input  logic              en_s1,
    output logic [DW-1:0]     c_out
);

    localparam logic [DW-1:0] C_MAX = {DW{1'b1}};

    logic [DW+8:0] p_q;
    logic [DW-1:0] y_q;
    logic [DW-1:0] lift_q;
    logic [DW+1:0] sum;
    logic [DW-1:0] c_nxt;

    // Stage 1: product with gain+1 so 255 maps to an exact x256; lift and
    // raw luma travel with the product so stage 2 never mixes samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q    <= '0;
            y_q    <= '0;
            lift_q <= '0;
        end else begin
            p_q    <= {9'd0, y_in} * {{DW{1'b0}}, ({1'b0, gain} + 9'd1)};
            y_q    <= y_in;
            lift_q <= lift;
        end
    end

    always_comb begin
        sum   = {1'b0, p_q[DW+8:8]} + {2'b00, lift_q};
        c_nxt = (sum[DW+1:DW] != 2'b00) ? C_MAX : sum[DW-1:0];
        if (!en_s1) begin
            c_nxt = y_q;
        end
    end

    // Stage 2 register
    always_ff @(posedge clk) begin
        if (reset) begin
            c_out <= '0;
        end else begin
            c_out <= c_nxt;
        end
    end

endmodule

// File: rtl/luma2rgb_tint.sv
// rtl/luma2rgb_tint.sv - luma to tinted RGB with frame-synchronous tint updates
//
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   enable                         1 = tint applied, 0 = grey passthrough
//   y_in                           luma sample
//   hs/vs/de/hb/vb_in              video timing, delayed 2 cycles to *_out
//   tint_r/g/b, lift, tint_wr      tint set and its write strobe
//   r_out, g_out, b_out            colourised pixel
module luma2rgb_tint
    import lumatint_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [DW-1:0] y_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          de_in,
    input  logic          hb_in,
    input  logic          vb_in,
    input  logic [7:0]    tint_r,
    input  logic [7:0]    tint_g,
    input  logic [7:0]    tint_b,
    input  logic [DW-1:0] lift,
    input  logic          tint_wr,
    output logic [DW-1:0] r_out,
    output logic [DW-1:0] g_out,
    output logic [DW-1:0] b_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          de_out,
    output logic          hb_out,
    output logic          vb_out
);

    tint_t         act_tint, pend_tint, act_tint_nxt, wr_tint;
    logic [DW-1:0] act_lift, pend_lift, act_lift_nxt;
    logic          pend_flag;
    logic          vb_q;
    logic          boundary;
    logic          en_s1;
    logic [4:0]    tim_s1, tim_s2;

    // The next active set is also what stage 1 consumes, so samples in the
    // boundary cycle already see the new tint.
    always_comb begin
        wr_tint      = '{r: tint_r, g: tint_g, b: tint_b};
        boundary     = vb_in & ~vb_q;
        act_tint_nxt = act_tint;
        act_lift_nxt = act_lift;
        if (boundary && tint_wr) begin
            act_tint_nxt = wr_tint;
            act_lift_nxt = lift;
        end else if (boundary && pend_flag) begin
            act_tint_nxt = pend_tint;
            act_lift_nxt = pend_lift;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_tint  <= '{r: TINT_UNITY, g: TINT_UNITY, b: TINT_UNITY};
            pend_tint <= '{r: TINT_UNITY, g: TINT_UNITY, b: TINT_UNITY};
            act_lift  <= '0;
            pend_lift <= '0;
            pend_flag <= 1'b0;
            vb_q      <= 1'b0;
        end else begin
            vb_q     <= vb_in;
            act_tint <= act_tint_nxt;
            act_lift <= act_lift_nxt;
            if (boundary) begin
                pend_flag <= 1'b0;
            end else if (tint_wr) begin
                pend_tint <= wr_tint;
                pend_lift <= lift;
                pend_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_s1  <= 1'b0;
            tim_s1 <= '0;
            tim_s2 <= '0;
        end else begin
            en_s1  <= enable;
            tim_s1 <= {hs_in, vs_in, de_in, hb_in, vb_in};
            tim_s2 <= tim_s1;
        end
    end

    assign {hs_out, vs_out, de_out, hb_out, vb_out} = tim_s2;

    lumatint_channel #(.DW(DW)) u_ch_r (
        .clk   (clk),
        .reset (reset),
        .y_in  (y_in),
        .gain  (act_tint_nxt.r),
        .lift  (act_lift_nxt),
        .en_s1 (en_s1),
        .c_out (r_out)
    );

    lumatint_channel #(.DW(DW)) u_ch_g (
        .clk   (clk),
        .reset (reset),
        .y_in  (y_in),
        .gain  (act_tint_nxt.g),
        .lift  (act_lift_nxt),
        .en_s1 (en_s1),
        .c_out (g_out)
    );

    lumatint_channel #(.DW(DW)) u_ch_b (
        .clk   (clk),
        .reset (reset),
        .y_in  (y_in),
        .gain  (act_tint_nxt.b),
        .lift  (act_lift_nxt),
        .en_s1 (en_s1),
        .c_out (b_out)
    );

endmodule

// File: tb/tb_luma2rgb_tint.sv
// tb/tb_luma2rgb_tint.sv - directed self-checking bench for luma2rgb_tint
module tb_luma2rgb_tint;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] y_in;
    logic       hs_in, vs_in, de_in, hb_in, vb_in;
    logic [7:0] tint_r, tint_g, tint_b;
    logic [7:0] lift;
    logic       tint_wr;
    logic [7:0] r_out, g_out, b_out;
    logic       hs_out, vs_out, de_out, hb_out, vb_out;

    int total = 0;
    int bad   = 0;

    logic [23:0] exp_q[0:9];

    luma2rgb_tint #(.DW(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .y_in    (y_in),
        .hs_in   (hs_in),
        .vs_in   (vs_in),
        .de_in   (de_in),
        .hb_in   (hb_in),
        .vb_in   (vb_in),
        .tint_r  (tint_r),
        .tint_g  (tint_g),
        .tint_b  (tint_b),
        .lift    (lift),
        .tint_wr (tint_wr),
        .r_out   (r_out),
        .g_out   (g_out),
        .b_out   (b_out),
        .hs_out  (hs_out),
        .vs_out  (vs_out),
        .de_out  (de_out),
        .hb_out  (hb_out),
        .vb_out  (vb_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tint(input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic [7:0] l);
        tint_r  = r;
        tint_g  = g;
        tint_b  = b;
        lift    = l;
        tint_wr = 1'b1;
        step();
        tint_wr = 1'b0;
    endtask

    function automatic logic [31:0] rgb3(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
        return {8'd0, r, g, b};
    endfunction

    function automatic logic [31:0] rgb_now();
        return {8'd0, r_out, g_out, b_out};
    endfunction

    function automatic logic [31:0] tim_now();
        return {27'd0, hs_out, vs_out, de_out, hb_out, vb_out};
    endfunction

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        y_in    = 8'd0;
        {hs_in, vs_in, de_in, hb_in, vb_in} = 5'b00000;
        tint_r  = 8'd0;
        tint_g  = 8'd0;
        tint_b  = 8'd0;
        lift    = 8'd0;
        tint_wr = 1'b0;

        step();
        step();
        chk("rst_rgb", rgb_now(), 32'd0);
        chk("rst_tim", tim_now(), 32'd0);

        // Unity passthrough after reset
        reset = 1'b0;
        y_in  = 8'd200;
        step();
        step();
        chk("unity", rgb_now(), rgb3(200, 200, 200));

        // Timing delayed by exactly two cycles
        hs_in = 1'b1; de_in = 1'b1; hb_in = 1'b1;
        step();
        chk("tim_lat1", tim_now(), 32'd0);
        step();
        chk("tim_lat2", tim_now(), 32'b10110);
        hs_in = 1'b0; de_in = 1'b0; hb_in = 1'b0;

        // Pending tint only takes effect at the vb rising edge
        set_tint(8'd255, 8'd128, 8'd0, 8'd0);
        step();
        step();
        chk("pre_edge", rgb_now(), rgb3(200, 200, 200));
        vb_in = 1'b1;
        step();
        chk("edge_old", rgb_now(), rgb3(200, 200, 200));
        step();
        chk("edge_new", rgb_now(), rgb3(200, 100, 0));

        // vb held high: no second boundary
        set_tint(8'd255, 8'd255, 8'd255, 8'd100);
        step();
        step();
        chk("vb_hold", rgb_now(), rgb3(200, 100, 0));
        vb_in = 1'b0;
        step();
        vb_in = 1'b1;
        step();
        step();
        chk("sat", rgb_now(), rgb3(255, 255, 255));
        y_in = 8'd0;
        step();
        step();
        chk("lift", rgb_now(), rgb3(100, 100, 100));

        // Grey bypass ignores gain and lift
        enable = 1'b0;
        y_in   = 8'd200;
        step();
        step();
        chk("bypass", rgb_now(), rgb3(200, 200, 200));
        enable = 1'b1;
        vb_in  = 1'b0;
        step();

        // Enable toggles with zero tint: every pixel all-0 or all-y
        set_tint(8'd0, 8'd0, 8'd0, 8'd0);
        vb_in = 1'b1;
        step();
        vb_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                y_in   = (i % 2 == 1) ? 8'd60 : 8'd50;
                enable = (i < 4);
            end
            exp_q[i] = enable ? 24'd0 : {y_in, y_in, y_in};
            step();
            if (i >= 1) begin
                chk($sformatf("mix%0d", i - 1), rgb_now(), {8'd0, exp_q[i-1]});
            end
        end
        enable = 1'b1;
        y_in   = 8'd200;

        // Last write wins; strobe coinciding with the boundary goes straight active
        set_tint(8'd10, 8'd10, 8'd10, 8'd0);
        set_tint(8'd20, 8'd20, 8'd20, 8'd0);
        step();
        tint_r  = 8'd30;
        tint_g  = 8'd30;
        tint_b  = 8'd30;
        tint_wr = 1'b1;
        vb_in   = 1'b1;
        step();
        tint_wr = 1'b0;
        step();
        chk("coinc", rgb_now(), rgb3(24, 24, 24));
        vb_in = 1'b0;
        step();
        vb_in = 1'b1;
        step();
        step();
        chk("pend_clr", rgb_now(), rgb3(24, 24, 24));
        vb_in = 1'b0;
        step();

        // Reset discards a pending tint
        set_tint(8'd255, 8'd128, 8'd0, 8'd5);
        reset = 1'b1;
        step();
        chk("rst2", rgb_now(), 32'd0);
        reset = 1'b0;
        y_in  = 8'd77;
        vb_in = 1'b1;
        step();
        step();
        chk("post_rst", rgb_now(), rgb3(77, 77, 77));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
